// File: rtl/wsram_pkg.sv
// Shared types and sizes for the weight SRAM access controller.
package wsram_pkg;

    localparam int unsigned WSRAM_ADDR_W    = 14;
    localparam int unsigned WSRAM_DATA_W    = 18;
    localparam int unsigned WSRAM_WORDS     = 16384;
    localparam int unsigned WSRAM_RSP_DEPTH = 2;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

endpackage

// File: rtl/wsram_rsp_fifo.sv
// Two-entry response FIFO with wrapping 1-bit pointers and an occupancy count.
module wsram_rsp_fifo
    import wsram_pkg::*;
#(
    parameter int unsigned DATA_W = WSRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/weight_sram_ctrl.sv
// Single-port weight SRAM controller: write/read round-robin arbitration,
// macro pin muxing and read-response buffering. Optional WSRAM_PERF_CNT_EN adds counters.
module weight_sram_ctrl
    import wsram_pkg::*;
#(
    parameter int unsigned ADDR_W    = WSRAM_ADDR_W,
    parameter int unsigned DATA_W    = WSRAM_DATA_W,
    parameter int unsigned RSP_DEPTH = WSRAM_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_cs,
    output logic              sram_web,
    output logic              sram_oe,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do,
    output logic              busy
`ifdef WSRAM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    grant_e            r_last_grant;
    logic              r_inflight;
    logic              r_oe;
    logic [ADDR_W-1:0] r_a_hold;
    logic [DATA_W-1:0] r_di_hold;

    logic              w_pop;
    logic [1:0]        w_count;
    logic [2:0]        w_used;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_gnt_wr;
    logic              w_gnt_rd;

    // Requests are masked while reset is asserted so all readies drop at once.
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_used    = 3'(w_count) + 3'(r_inflight);
    assign w_wr_elig = wr_valid && rst_n;
    assign w_rd_elig = rd_valid && rst_n && ((3'(RSP_DEPTH) + 3'(w_pop)) > w_used);

    always_comb begin
        w_gnt_wr = 1'b0;
        w_gnt_rd = 1'b0;
        if (w_wr_elig && w_rd_elig) begin
            if (r_last_grant == GNT_READ) begin
                w_gnt_wr = 1'b1;
            end else begin
                w_gnt_rd = 1'b1;
            end
        end else begin
            w_gnt_wr = w_wr_elig;
            w_gnt_rd = w_rd_elig;
        end
    end

    // Address and data fall back to their last driven values when idle.
    assign wr_ready = w_gnt_wr;
    assign rd_ready = w_gnt_rd;
    assign sram_cs  = w_gnt_wr || w_gnt_rd;
    assign sram_web = !w_gnt_wr;
    assign sram_oe  = r_oe;
    assign sram_a   = w_gnt_wr ? wr_addr : (w_gnt_rd ? rd_addr : r_a_hold);
    assign sram_di  = w_gnt_wr ? wr_data : r_di_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_READ;
            r_inflight   <= 1'b0;
            r_oe         <= 1'b0;
            r_a_hold     <= '0;
            r_di_hold    <= '0;
        end else begin
            r_oe       <= 1'b1;
            r_inflight <= w_gnt_rd;
            r_a_hold   <= sram_a;
            r_di_hold  <= sram_di;
            if (w_gnt_wr) begin
                r_last_grant <= GNT_WRITE;
            end else if (w_gnt_rd) begin
                r_last_grant <= GNT_READ;
            end
        end
    end

    // Macro read data is valid the cycle after the read edge; capture it then.
    wsram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (sram_do),
        .i_pop       (w_pop),
        .o_rd_data   (rsp_data),
        .o_count     (w_count)
    );

    assign rsp_valid = (w_count != 2'd0);
    assign busy      = r_inflight || rsp_valid;

`ifdef WSRAM_PERF_CNT_EN
    logic [31:0] r_perf_rd;
    logic [31:0] r_perf_wr;
    logic [31:0] r_perf_stall;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_rd    <= '0;
            r_perf_wr    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_gnt_rd && !(&r_perf_rd)) begin
                r_perf_rd <= r_perf_rd + 32'd1;
            end
            if (w_gnt_wr && !(&r_perf_wr)) begin
                r_perf_wr <= r_perf_wr + 32'd1;
            end
            if (rd_valid && !w_gnt_rd && !(&r_perf_stall)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_rd_cnt    = r_perf_rd;
    assign perf_wr_cnt    = r_perf_wr;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Self-checking bench for weight_sram_ctrl with an SRAM macro model and a
// transaction-level reference (memory image plus ordered expected-response queue).
module tb_weight_sram_ctrl;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 18;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          sram_cs;
    logic          sram_web;
    logic          sram_oe;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_di;
    logic [DW-1:0] sram_do;
    logic          busy;
`ifdef WSRAM_PERF_CNT_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    weight_sram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .sram_cs   (sram_cs),
        .sram_web  (sram_web),
        .sram_oe   (sram_oe),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do),
        .busy      (busy)
`ifdef WSRAM_PERF_CNT_EN
        ,
        .perf_rd_cnt    (perf_rd_cnt),
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: write at the edge, read data appears one cycle later.
    logic [DW-1:0] sram_mem [0:16383];
    always @(posedge clk) begin
        if (sram_cs && !sram_web) sram_mem[sram_a] <= sram_di;
        if (sram_cs && sram_web)  sram_do <= sram_mem[sram_a];
    end

    typedef struct {
        logic [DW-1:0] d;
        int            k;
    } rsp_t;

    rsp_t          q[$];
    logic [DW-1:0] ref_mem [0:16383];
    int            edge_n;
    bit            last_wr;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_di;
    bit            oe_exp;
    int            checks;
    int            failures;
    int            n_pops;
    string         glog;
    bit            obs_valid;
    logic [DW-1:0] obs_data;
    bit            cyc_gw;
    bit            cyc_gr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check DUT outputs mid-cycle against the reference, then apply the edge.
    task automatic cycle();
        bit            ev;
        bit            pop;
        bit            relig;
        bit            gw;
        bit            gr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        ev    = (q.size() != 0) && (q[0].k + 2 <= edge_n);
        pop   = ev && rsp_ready;
        relig = rd_valid && (2 - q.size() + int'(pop) >= 1);
        gw    = wr_valid && (!relig || !last_wr);
        gr    = relig && (!wr_valid || last_wr);
        ea    = gw ? wr_addr : (gr ? rd_addr : exp_a);
        ed    = gw ? wr_data : exp_di;
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) check("rsp_data", 32'(rsp_data), 32'(q[0].d));
        check("wr_ready", 32'(wr_ready), 32'(gw));
        check("rd_ready", 32'(rd_ready), 32'(gr));
        check("sram_cs", 32'(sram_cs), 32'(gw || gr));
        check("sram_web", 32'(sram_web), 32'(!gw));
        check("sram_a", 32'(sram_a), 32'(ea));
        check("sram_di", 32'(sram_di), 32'(ed));
        check("sram_oe", 32'(sram_oe), 32'(oe_exp));
        check("busy", 32'(busy), 32'(q.size() != 0));
        obs_valid = rsp_valid;
        obs_data  = rsp_data;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            n_pops++;
        end
        if (gw) begin
            ref_mem[wr_addr] = wr_data;
            last_wr = 1'b1;
            glog = {glog, "W"};
        end
        if (gr) begin
            q.push_back('{d: ref_mem[rd_addr], k: edge_n});
            last_wr = 1'b0;
            glog = {glog, "R"};
        end
        cyc_gw = gw;
        cyc_gr = gr;
        exp_a  = ea;
        exp_di = ed;
        oe_exp = 1'b1;
        edge_n++;
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        while (q.size() != 0 && guard < 20) begin
            cycle();
            guard++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        last_wr = 1'b0;
        exp_a   = '0;
        exp_di  = '0;
        oe_exp  = 1'b0;
    endtask

    initial begin
        int ri;
        int wi;
        int cnt;
        int pops0;
        int guard;

        checks = 0; failures = 0; edge_n = 0; n_pops = 0; glog = "";
        wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset values hold even with both requests asserted.
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_cs", 32'(sram_cs), 32'd0);
        check("rst_web", 32'(sram_web), 32'd1);
        check("rst_oe", 32'(sram_oe), 32'd0);
        check("rst_a", 32'(sram_a), 32'd0);
        check("rst_di", 32'(sram_di), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) cycle();
        check("oe_after_edge", 32'(sram_oe), 32'd1);

        // Preload the small working set used by every test.
        for (int a = 0; a < 32; a++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(a);
            wr_data  = DW'($urandom);
            cycle();
        end
        wr_valid = 1'b0;

        // Write then read the same address on the next cycle.
        wr_valid = 1'b1; wr_addr = 14'h0010; wr_data = 18'h2A5F5;
        cycle();
        check("wr10_acc", 32'(cyc_gw), 32'd1);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 14'h0010; rsp_ready = 1'b1;
        cycle();
        check("rd10_acc", 32'(cyc_gr), 32'd1);
        rd_valid = 1'b0;
        cycle();
        check("lat_edge1_valid", 32'(obs_valid), 32'd0);
        cycle();
        check("lat_edge2_valid", 32'(obs_valid), 32'd1);
        check("lat_data", 32'(obs_data), 32'h2A5F5);
        drain();

        // Both sides requesting: strict alternation starting with the write.
        glog = ""; wi = 0; ri = 0;
        wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_addr = AW'(14'h0100 + wi);
            wr_data = DW'($urandom);
            rd_addr = AW'(ri);
            cycle();
            if (cyc_gw) wi++;
            if (cyc_gr) ri++;
        end
        check("arb_pattern", 32'(glog == "WRWRWR"), 32'd1);
        drain();

        // Back-to-back reads with the consumer always ready.
        rd_valid = 1'b1; rsp_ready = 1'b1; ri = 0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = AW'(ri);
            cycle();
            if (cyc_gr) begin ri++; cnt++; end
        end
        check("b2b_reads", 32'(cnt), 32'd10);
        drain();

        // Same stream with the consumer stalled, then released.
        rd_valid = 1'b1; rsp_ready = 1'b0; ri = 0; cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rd_addr = AW'(ri);
            cycle();
            if (cyc_gr) begin ri++; cnt++; end
        end
        check("bp_accepts", 32'(cnt), 32'd2);
        check("bp_rd_ready_low", 32'(cyc_gr), 32'd0);
        check("bp_hold_data", 32'(obs_data), 32'(ref_mem[0]));
        rsp_ready = 1'b1; pops0 = n_pops; guard = 0;
        while (ri < 10 && guard < 40) begin
            rd_addr = AW'(ri);
            cycle();
            if (cyc_gr) ri++;
            guard++;
        end
        check("bp_resume_reads", 32'(ri), 32'd10);
        drain();
        check("bp_total_pops", 32'(n_pops - pops0), 32'd10);

        // Randomised traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            wr_valid  = 1'($urandom_range(0, 1));
            rd_valid  = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            wr_addr   = AW'($urandom_range(0, 31));
            wr_data   = DW'($urandom);
            rd_addr   = AW'($urandom_range(0, 31));
            cycle();
        end
        drain();

        // Reset asserted the cycle after a read accept.
        rd_valid = 1'b1; rd_addr = 14'h0005; rsp_ready = 1'b1;
        cycle();
        check("mid_rd_acc", 32'(cyc_gr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_ready", 32'(rd_ready), 32'd0);
        check("mid_rst_cs", 32'(sram_cs), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_oe", 32'(sram_oe), 32'd0);
        model_reset();
        rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("post_rst_no_rsp", 32'(obs_valid), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);
`ifdef WSRAM_PERF_CNT_EN
        check("perf_rd_zero", perf_rd_cnt, 32'd0);
        check("perf_wr_zero", perf_wr_cnt, 32'd0);
        check("perf_stall_zero", perf_stall_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
